// File: rtl/bit_splitter_pkg.sv
// Shared types for the wide-to-narrow bit splitter.
package bit_splitter_pkg;
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;
endpackage

// File: rtl/bit_splitter_if.sv
// Input/output stream handshake bundle for bit_splitter.
interface bit_splitter_if #(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 6
) ();
  localparam int OBW = $clog2(OWIDTH + 1);

  logic [IWIDTH-1:0] in;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [OWIDTH-1:0] out;
  logic [OBW-1:0]    out_bits;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in, in_valid, in_last, out_ready,
    output in_ready, out, out_bits, out_last, out_valid
  );
  modport master (
    output in, in_valid, in_last, out_ready,
    input  in_ready, out, out_bits, out_last, out_valid
  );
endinterface

// File: rtl/bit_splitter.sv
// Slices IWIDTH-bit words into an MSB-first stream of OWIDTH-bit words;
// in_last flushes a right-aligned partial word.
module bit_splitter
  import bit_splitter_pkg::*;
#(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  bit_splitter_if.slave bus
);
  localparam int BWIDTH = IWIDTH + OWIDTH - 1;
  // count must also represent 2*OWIDTH for the in_ready compare
  localparam int CW     = $clog2(IWIDTH + 2*OWIDTH);
  localparam int OBW    = $clog2(OWIDTH + 1);
  localparam logic [CW-1:0] OW_C  = CW'(OWIDTH);
  localparam logic [CW-1:0] OW2_C = CW'(2*OWIDTH);
  localparam logic [CW-1:0] IW_C  = CW'(IWIDTH);

  function automatic logic [BWIDTH-1:0] lo_mask(input logic [CW-1:0] n);
    return ~({BWIDTH{1'b1}} << n);
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [BWIDTH-1:0] buf_q, buf_d;

  logic              full, part;
  logic              out_valid, out_last, in_ready;
  logic [OWIDTH-1:0] out_data;
  logic [OBW-1:0]    out_bits;
  logic              out_fire, in_fire;
  logic [CW-1:0]     rem;

  // Output side is a pure function of registered state.
  always_comb begin
    full      = (count_q >= OW_C);
    part      = (state_q == DRAIN) && (count_q != '0);
    out_valid = full || part;
    out_data  = '0;
    out_bits  = '0;
    out_last  = 1'b0;
    if (full) begin
      out_data = OWIDTH'(buf_q >> (count_q - OW_C));
      out_bits = OBW'(OWIDTH);
      out_last = (state_q == DRAIN) && (count_q == OW_C);
    end else if (part) begin
      out_data = OWIDTH'(buf_q & lo_mask(count_q));
      out_bits = OBW'(count_q);
      out_last = 1'b1;
    end
  end

  // Accept when the post-emit residue plus a new word still fits in the buffer.
  assign in_ready = (state_q == FILL) &&
                    ((count_q < OW_C) || ((count_q < OW2_C) && bus.out_ready));

  assign out_fire = out_valid && bus.out_ready;
  assign in_fire  = bus.in_valid && in_ready;

  always_comb begin
    rem     = count_q - (out_fire ? CW'(out_bits) : '0);
    state_d = state_q;
    count_d = rem;
    buf_d   = buf_q;
    if (in_fire) begin
      buf_d   = ((buf_q & lo_mask(rem)) << IWIDTH) | BWIDTH'(bus.in);
      count_d = rem + IW_C;
      if (bus.in_last) state_d = DRAIN;
    end
    if ((state_q == DRAIN) && out_fire && out_last) begin
      state_d = FILL;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      count_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_data;
  assign bus.out_bits  = out_bits;
  assign bus.out_last  = out_last;
  assign bus.out_valid = out_valid;
endmodule
